// File: rtl/branch_predict_unit.sv
// Branch prediction state for the fetch stage: a direct-mapped BTB, a gshare
// PHT of 2-bit saturating counters, and the global history register.
// Lookups are registered, so results appear one cycle after the lookup.
// Resolved branches arrive on the upd* port and commit at the next posedge.
// Optional build macro BPU_WRITE_BYPASS_EN: when a lookup and an update hit
// the same BTB or PHT entry in the same cycle, the lookup sees the new
// contents. Without the macro, the lookup sees the old contents.
module branch_predict_unit #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned BTB_INDEX_WIDTH = 4,
    parameter int unsigned GHR_WIDTH       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetchPc,
    input  logic                  fetchStall,
    output logic                  btbHit,
    output logic [ADDR_WIDTH-1:0] btbPredictedPc,
    output logic                  isBranchTakenPredicted,
    output logic [GHR_WIDTH-1:0]  globalBranchHistory,
    input  logic                  updValid,
    input  logic [ADDR_WIDTH-1:0] updPc,
    input  logic [ADDR_WIDTH-1:0] updTarget,
    input  logic                  updTaken,
    input  logic                  updConditional,
    input  logic [GHR_WIDTH-1:0]  updHistory
);

    localparam int unsigned BTB_ENTRIES = 1 << BTB_INDEX_WIDTH;
    localparam int unsigned PHT_ENTRIES = 1 << GHR_WIDTH;
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

    // Prediction state; every array is a flop array so that reset can clear it
    logic                  btb_valid  [BTB_ENTRIES];
    logic [TAG_WIDTH-1:0]  btb_tag    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]            pht        [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0]  ghr;

    // Index, tag, and gshare-index slices for the lookup and update ports
    logic [BTB_INDEX_WIDTH-1:0] rd_idx;
    logic [TAG_WIDTH-1:0]       rd_tag;
    logic [GHR_WIDTH-1:0]       rd_pidx;
    logic [BTB_INDEX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0]       upd_tag;
    logic [GHR_WIDTH-1:0]       upd_pidx;

    assign rd_idx   = fetchPc[BTB_INDEX_WIDTH+1:2];
    assign rd_tag   = fetchPc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
    assign rd_pidx  = fetchPc[GHR_WIDTH+1:2] ^ ghr;
    assign upd_idx  = updPc[BTB_INDEX_WIDTH+1:2];
    assign upd_tag  = updPc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
    assign upd_pidx = updPc[GHR_WIDTH+1:2] ^ updHistory;

    // The two low bits of each PC (byte offset) are never used
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetchPc[1:0], updPc[1:0]};

    assign globalBranchHistory = ghr;

    // Next value of the counter being updated: saturating +1 or -1
    logic [1:0] pht_next_c;
    always_comb begin
        pht_next_c = pht[upd_pidx];
        if (updTaken) begin
            if (pht[upd_pidx] != 2'b11) pht_next_c = pht[upd_pidx] + 2'd1;
        end else begin
            if (pht[upd_pidx] != 2'b00) pht_next_c = pht[upd_pidx] - 2'd1;
        end
    end

    // Lookup result for the current fetchPc, optionally forwarding the update
    logic                  rd_hit_c;
    logic [ADDR_WIDTH-1:0] rd_target_c;
    logic                  rd_taken_c;
    always_comb begin
        rd_hit_c    = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
        rd_target_c = btb_target[rd_idx];
        rd_taken_c  = pht[rd_pidx][1];
`ifdef BPU_WRITE_BYPASS_EN
        if (updValid && updTaken && (upd_idx == rd_idx)) begin
            rd_hit_c    = (upd_tag == rd_tag);
            rd_target_c = updTarget;
        end
        if (updValid && updConditional && (upd_pidx == rd_pidx)) begin
            rd_taken_c = pht_next_c[1];
        end
`endif
    end

    // State update: reset, registered lookup, and branch-resolution writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_valid[i] <= 1'b0;
            end
            for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
                pht[i] <= 2'b01;
            end
            ghr                    <= '0;
            btbHit                 <= 1'b0;
            btbPredictedPc         <= '0;
            isBranchTakenPredicted <= 1'b0;
        end else begin
            if (!fetchStall) begin
                btbHit                 <= rd_hit_c;
                btbPredictedPc         <= rd_hit_c ? rd_target_c : '0;
                isBranchTakenPredicted <= rd_taken_c;
            end
            if (updValid) begin
                if (updTaken) begin
                    btb_valid[upd_idx]  <= 1'b1;
                    btb_tag[upd_idx]    <= upd_tag;
                    btb_target[upd_idx] <= updTarget;
                end
                if (updConditional) begin
                    pht[upd_pidx] <= pht_next_c;
                    ghr           <= {ghr[GHR_WIDTH-2:0], updTaken};
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a table of per-cycle vectors
// followed by hand-written collision and reset-during-update sequences.
// Expected outputs are queued when a cycle is driven and popped after the edge.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetchPc;
    logic        fetchStall;
    logic        btbHit;
    logic [31:0] btbPredictedPc;
    logic        isBranchTakenPredicted;
    logic [5:0]  globalBranchHistory;
    logic        updValid;
    logic [31:0] updPc;
    logic [31:0] updTarget;
    logic        updTaken;
    logic        updConditional;
    logic [5:0]  updHistory;

    branch_predict_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .fetchPc                (fetchPc),
        .fetchStall             (fetchStall),
        .btbHit                 (btbHit),
        .btbPredictedPc         (btbPredictedPc),
        .isBranchTakenPredicted (isBranchTakenPredicted),
        .globalBranchHistory    (globalBranchHistory),
        .updValid               (updValid),
        .updPc                  (updPc),
        .updTarget              (updTarget),
        .updTaken               (updTaken),
        .updConditional         (updConditional),
        .updHistory             (updHistory)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] fpc;
        logic        stall;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        ucond;
        logic [5:0]  uhist;
        logic        e_hit;
        logic [31:0] e_pc;
        logic        e_tk;
        logic [5:0]  e_ghr;
    } vec_t;

    typedef struct {
        int          id;
        logic        hit;
        logic [31:0] pc;
        logic        tk;
        logic [5:0]  ghr;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    vec_t vecs[19];

    function automatic vec_t mk(logic r, logic [31:0] fpc, logic stall,
                                logic uv, logic [31:0] upc, logic [31:0] utgt,
                                logic utk, logic ucond, logic [5:0] uhist,
                                logic eh, logic [31:0] epc, logic etk,
                                logic [5:0] eg);
        vec_t v;
        v.rst = r; v.fpc = fpc; v.stall = stall; v.uv = uv; v.upc = upc;
        v.utgt = utgt; v.utk = utk; v.ucond = ucond; v.uhist = uhist;
        v.e_hit = eh; v.e_pc = epc; v.e_tk = etk; v.e_ghr = eg;
        return v;
    endfunction

    task automatic chk1(string name, int id, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, name, act, req);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic apply(vec_t v);
        exp_t e;
        exp_t got;
        rst = v.rst; fetchPc = v.fpc; fetchStall = v.stall;
        updValid = v.uv; updPc = v.upc; updTarget = v.utgt;
        updTaken = v.utk; updConditional = v.ucond; updHistory = v.uhist;
        e.id = step_id; e.hit = v.e_hit; e.pc = v.e_pc; e.tk = v.e_tk; e.ghr = v.e_ghr;
        scb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        if (scb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at step %0d", step_id);
        end else begin
            got = scb.pop_front();
            chk1("btbHit", got.id, 32'(btbHit), 32'(got.hit));
            chk1("btbPredictedPc", got.id, btbPredictedPc, got.pc);
            chk1("isBranchTakenPredicted", got.id, 32'(isBranchTakenPredicted), 32'(got.tk));
            chk1("globalBranchHistory", got.id, 32'(globalBranchHistory), 32'(got.ghr));
        end
    endtask

    initial begin
        //            rst fetchPc   st uv updPc     target    tk cd hist  hit pc        tk ghr
        vecs[0]  = mk(1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 0, 32'h0,   0, 6'h00);
        vecs[1]  = mk(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 0, 32'h0,   0, 6'h00);
        vecs[2]  = mk(0, 32'h104, 0, 1, 32'h104, 32'h200, 1, 0, 6'h0, 0, 32'h0,   0, 6'h00);
        vecs[3]  = mk(0, 32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 1, 32'h200, 0, 6'h00);
        vecs[4]  = mk(0, 32'h144, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 0, 32'h0,   0, 6'h00);
        vecs[5]  = mk(0, 32'h100, 0, 1, 32'h108, 32'h300, 1, 1, 6'h0, 0, 32'h0,   0, 6'h01);
        vecs[6]  = mk(0, 32'h100, 0, 1, 32'h108, 32'h300, 1, 1, 6'h0, 0, 32'h0,   0, 6'h03);
        vecs[7]  = mk(0, 32'h104, 0, 1, 32'h108, 32'h300, 1, 1, 6'h0, 1, 32'h200, 1, 6'h07);
        vecs[8]  = mk(0, 32'h114, 0, 1, 32'h108, 32'h300, 0, 1, 6'h0, 0, 32'h0,   1, 6'h0E);
        vecs[9]  = mk(0, 32'h130, 0, 1, 32'h108, 32'h300, 0, 1, 6'h0, 0, 32'h0,   1, 6'h1C);
        vecs[10] = mk(0, 32'h178, 0, 1, 32'h108, 32'h300, 0, 1, 6'h0, 0, 32'h0,   0, 6'h38);
        vecs[11] = mk(0, 32'h0E8, 0, 1, 32'h108, 32'h300, 0, 1, 6'h0, 0, 32'h0,   0, 6'h30);
        vecs[12] = mk(0, 32'h0C8, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 0, 32'h0,   0, 6'h30);
        vecs[13] = mk(0, 32'h108, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 1, 32'h300, 0, 6'h30);
        vecs[14] = mk(0, 32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 1, 32'h200, 0, 6'h30);
        vecs[15] = mk(0, 32'h300, 1, 1, 32'h144, 32'h500, 1, 0, 6'h0, 1, 32'h200, 0, 6'h30);
        vecs[16] = mk(0, 32'h300, 1, 0, 32'h0,   32'h0,   0, 0, 6'h0, 1, 32'h200, 0, 6'h30);
        vecs[17] = mk(0, 32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 0, 32'h0,   0, 6'h30);
        vecs[18] = mk(0, 32'h144, 0, 0, 32'h0,   32'h0,   0, 0, 6'h0, 1, 32'h500, 0, 6'h30);

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i]);
        end

        // BTB collision: lookup and taken update of 0x110 in the same cycle
`ifdef BPU_WRITE_BYPASS_EN
        apply(mk(0, 32'h110, 0, 1, 32'h110, 32'h400, 1, 0, 6'h0, 1, 32'h400, 0, 6'h30));
`else
        apply(mk(0, 32'h110, 0, 1, 32'h110, 32'h400, 1, 0, 6'h0, 0, 32'h0,   0, 6'h30));
`endif
        apply(mk(0, 32'h110, 0, 0, 32'h0, 32'h0, 0, 0, 6'h0, 1, 32'h400, 0, 6'h30));

        // PHT and BTB collision: conditional taken update aliasing the lookup
`ifdef BPU_WRITE_BYPASS_EN
        apply(mk(0, 32'h100, 0, 1, 32'h100, 32'h600, 1, 1, 6'h30, 1, 32'h600, 1, 6'h21));
`else
        apply(mk(0, 32'h100, 0, 1, 32'h100, 32'h600, 1, 1, 6'h30, 0, 32'h0,   0, 6'h21));
`endif
        apply(mk(0, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0, 6'h0, 1, 32'h600, 0, 6'h21));

        // Reset in the same cycle as a taken conditional update discards it
        apply(mk(1, 32'h104, 0, 1, 32'h104, 32'h700, 1, 1, 6'h0, 0, 32'h0, 0, 6'h00));
        apply(mk(0, 32'h104, 0, 0, 32'h0, 32'h0, 0, 0, 6'h0, 0, 32'h0, 0, 6'h00));
        apply(mk(0, 32'h110, 0, 0, 32'h0, 32'h0, 0, 0, 6'h0, 0, 32'h0, 0, 6'h00));

        if (scb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard left %0d entries", scb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
